// File: rtl/bias_load_ctrl.sv
// Bias memory loader: unpacks a stream of 2*BIAS_WIDTH-bit words into
// consecutive BIAS_WIDTH-bit writes at addresses 0..load_num-1.
module bias_load_ctrl #(
  parameter int WR_ADDR_DEPTH = 9,
  parameter int BIAS_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       load_start,
  input  logic [WR_ADDR_DEPTH:0]     load_num,
  input  logic [2*BIAS_WIDTH-1:0]    s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [WR_ADDR_DEPTH-1:0]   addr_wr,
  output logic [BIAS_WIDTH-1:0]      data_wr,
  output logic                       wr_en,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       BiasMem_ready
);

  localparam int CW = WR_ADDR_DEPTH + 1;
  localparam logic [CW-1:0] MAX_NUM = CW'(1) << WR_ADDR_DEPTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Hold register: the low half of an accepted word goes straight to the
  // write port, so only the pending high half needs to be kept.
  logic [BIAS_WIDTH-1:0]    hold_half;
  logic                     hold_valid;
  logic                     half_idx;     // 0: low half on the port, 1: high half on the port
  logic [CW-1:0]            words_left;   // input words still to accept
  logic [CW-1:0]            wr_left;      // writes still to issue
  logic [WR_ADDR_DEPTH-1:0] wr_ptr;       // address of the next write

  logic          start_accept;
  logic          handshake;
  logic          emit_high;
  logic [CW-1:0] num_clamped;
  logic [CW:0]   num_plus_one;
  logic [CW-1:0] words_init;

  assign start_accept = (state == IDLE) && load_start;
  assign num_clamped  = (load_num > MAX_NUM) ? MAX_NUM : load_num;
  assign num_plus_one = {1'b0, num_clamped} + (CW+1)'(1);
  assign words_init   = num_plus_one[CW:1];
  assign handshake    = s_valid && s_ready;

  // The high half is emitted only if a write is still owed; otherwise it is
  // the discarded tail of an odd-length load.
  assign emit_high    = hold_valid && !half_idx && (wr_left != '0);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values of the others.
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE: if (load_start) state_nxt = (num_clamped == '0) ? DONE : LOAD;
      LOAD: if (wr_en && (wr_left == '0)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load_busy = (state == LOAD);
    load_done = (state == DONE);
    s_ready   = (state == LOAD) && (!hold_valid || half_idx) && (words_left != '0);
  end

  // Datapath: hold register, counters and registered write port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_half     <= '0;
      hold_valid    <= 1'b0;
      half_idx      <= 1'b0;
      words_left    <= '0;
      wr_left       <= '0;
      wr_ptr        <= '0;
      wr_en         <= 1'b0;
      addr_wr       <= '0;
      data_wr       <= '0;
      BiasMem_ready <= 1'b0;
    end else begin
      wr_en <= 1'b0;

      if (start_accept) begin
        hold_valid <= 1'b0;
        half_idx   <= 1'b0;
        words_left <= words_init;
        wr_left    <= num_clamped;
        wr_ptr     <= '0;
      end else if (state == LOAD) begin
        if (handshake) begin
          hold_half  <= s_data[2*BIAS_WIDTH-1:BIAS_WIDTH];
          hold_valid <= 1'b1;
          half_idx   <= 1'b0;
          words_left <= words_left - CW'(1);
          wr_en      <= 1'b1;
          addr_wr    <= wr_ptr;
          data_wr    <= s_data[BIAS_WIDTH-1:0];
          wr_ptr     <= wr_ptr + WR_ADDR_DEPTH'(1);
          wr_left    <= wr_left - CW'(1);
        end else if (emit_high) begin
          half_idx   <= 1'b1;
          wr_en      <= 1'b1;
          addr_wr    <= wr_ptr;
          data_wr    <= hold_half;
          wr_ptr     <= wr_ptr + WR_ADDR_DEPTH'(1);
          wr_left    <= wr_left - CW'(1);
        end else begin
          hold_valid <= 1'b0;
        end
      end else begin
        hold_valid <= 1'b0;
      end

      // Set has priority so a zero-length load still reports a complete set.
      if (state_nxt == DONE && state != DONE) BiasMem_ready <= 1'b1;
      else if (start_accept)                  BiasMem_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bias_load_ctrl.sv
// Directed bench for bias_load_ctrl: table-driven load vectors plus
// hand-written reset, zero-length, clamp and mid-load-reset sequences.
module tb_bias_load_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load_start;
  logic [9:0]  load_num;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [8:0]  addr_wr;
  logic [15:0] data_wr;
  logic        wr_en;
  logic        load_busy;
  logic        load_done;
  logic        BiasMem_ready;

  bias_load_ctrl #(.WR_ADDR_DEPTH(9), .BIAS_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .load_start(load_start), .load_num(load_num),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .addr_wr(addr_wr), .data_wr(data_wr), .wr_en(wr_en),
    .load_busy(load_busy), .load_done(load_done), .BiasMem_ready(BiasMem_ready)
  );

  always #5 clk = ~clk;

  // Monitor: values read at the rising edge are the pre-edge values.
  int         cyc_cnt  = 0;
  int         hs_cnt   = 0;
  int         done_cnt = 0;
  logic [8:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (s_valid && s_ready) hs_cnt <= hs_cnt + 1;
    if (load_done) done_cnt <= done_cnt + 1;
    if (wr_en) begin
      wa_q.push_back(addr_wr);
      wd_q.push_back(data_wr);
      wc_q.push_back(cyc_cnt);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          num;
    int          nwords;
    logic [31:0] w[4];
    bit          rnd;
    bit          mid;
    int          exp_wr;
    int          exp_hs;
    logic [15:0] exp_d[6];
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] words_buf[300];

  // Drives one load and feeds words_buf; returns at load_done (or when
  // abort_wr writes have been seen, if abort_wr > 0).
  task automatic run_load(input string tag, input int num, input int nwords,
                          input bit rnd, input bit mid, input int abort_wr);
    int base_hs, base_done, base_wr, idx;
    base_hs   = hs_cnt;
    base_done = done_cnt;
    base_wr   = wa_q.size();
    @(negedge clk);
    load_num   = 10'(num);
    load_start = 1'b1;
    s_valid    = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check({tag, "_ready_cleared"}, 32'(BiasMem_ready), 32'd0);
        check({tag, "_busy"}, 32'(load_busy), 32'd1);
      end
      if (done_cnt > base_done) break;
      if (abort_wr > 0 && (wa_q.size() - base_wr) >= abort_wr) break;
      idx        = hs_cnt - base_hs;
      load_start = mid && (cyc == 4);
      if (mid && cyc == 4) load_num = 10'd2;
      if (idx < nwords) s_data = words_buf[idx];
      s_valid = (idx < nwords) && (!rnd || ($urandom_range(0, 1) == 1));
    end
    load_start = 1'b0;
    s_valid    = 1'b0;
    if (abort_wr == 0) begin
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, 32'(done_cnt - base_done), 32'd1);
      check({tag, "_mem_ready"}, 32'(BiasMem_ready), 32'd1);
      check({tag, "_busy_after"}, 32'(load_busy), 32'd0);
    end
  endtask

  int wr_base, hs_base, snap, errs;

  initial begin
    rstn = 1'b0; load_start = 1'b0; load_num = '0; s_data = '0; s_valid = 1'b0;

    vecs[0] = '{num: 4, nwords: 2, w: '{32'h0002_0001, 32'h0004_0003, 32'h0, 32'h0},
                rnd: 0, mid: 0, exp_wr: 4, exp_hs: 2,
                exp_d: '{16'h1, 16'h2, 16'h3, 16'h4, 16'h0, 16'h0}};
    vecs[1] = '{num: 3, nwords: 2, w: '{32'h0020_0010, 32'h0040_0030, 32'h0, 32'h0},
                rnd: 0, mid: 0, exp_wr: 3, exp_hs: 2,
                exp_d: '{16'h10, 16'h20, 16'h30, 16'h0, 16'h0, 16'h0}};
    vecs[2] = '{num: 5, nwords: 3, w: '{32'hBBBB_AAAA, 32'hDDDD_CCCC, 32'hFFFF_EEEE, 32'h0},
                rnd: 1, mid: 1, exp_wr: 5, exp_hs: 3,
                exp_d: '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'h0}};
    vecs[3] = '{num: 1, nwords: 1, w: '{32'h5678_1234, 32'h0, 32'h0, 32'h0},
                rnd: 0, mid: 0, exp_wr: 1, exp_hs: 1,
                exp_d: '{16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_addr", 32'(addr_wr), 32'd0);
    check("rst_data", 32'(data_wr), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_mem_ready", 32'(BiasMem_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Zero-length load: straight to DONE, no writes, no handshakes
    @(negedge clk);
    wr_base = wa_q.size();
    hs_base = hs_cnt;
    load_num = 10'd0; load_start = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("zero_done_hi", 32'(load_done), 32'd1);
    check("zero_s_ready", 32'(s_ready), 32'd0);
    check("zero_busy", 32'(load_busy), 32'd0);
    @(negedge clk);
    load_start = 1'b0;
    @(posedge clk);
    #1;
    check("zero_done_lo", 32'(load_done), 32'd0);
    check("zero_s_ready2", 32'(s_ready), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    check("zero_writes", 32'(wa_q.size() - wr_base), 32'd0);
    check("zero_hs", 32'(hs_cnt - hs_base), 32'd0);

    // Table-driven loads
    foreach (vecs[v]) begin
      for (int k = 0; k < 4; k++) words_buf[k] = vecs[v].w[k];
      wr_base = wa_q.size();
      hs_base = hs_cnt;
      run_load($sformatf("vec%0d", v), vecs[v].num, vecs[v].nwords, vecs[v].rnd, vecs[v].mid, 0);
      check($sformatf("vec%0d_nwr", v), 32'(wa_q.size() - wr_base), 32'(vecs[v].exp_wr));
      check($sformatf("vec%0d_nhs", v), 32'(hs_cnt - hs_base), 32'(vecs[v].exp_hs));
      for (int i = 0; i < vecs[v].exp_wr && (wr_base + i) < wa_q.size(); i++) begin
        check($sformatf("vec%0d_addr%0d", v, i), 32'(wa_q[wr_base + i]), 32'(i));
        check($sformatf("vec%0d_data%0d", v, i), 32'(wd_q[wr_base + i]), 32'(vecs[v].exp_d[i]));
      end
      if (!vecs[v].rnd && (wa_q.size() - wr_base) == vecs[v].exp_wr)
        check($sformatf("vec%0d_back_to_back", v),
              32'(wc_q[wa_q.size() - 1] - wc_q[wr_base]), 32'(vecs[v].exp_wr - 1));
    end

    // Clamp: 517 requested, 512 written from 256 words
    for (int k = 0; k < 300; k++) words_buf[k] = {16'(2 * k + 1), 16'(2 * k)};
    wr_base = wa_q.size();
    hs_base = hs_cnt;
    run_load("clamp", 517, 300, 0, 0, 0);
    check("clamp_nwr", 32'(wa_q.size() - wr_base), 32'd512);
    check("clamp_nhs", 32'(hs_cnt - hs_base), 32'd256);
    errs = 0;
    for (int i = 0; (wr_base + i) < wa_q.size(); i++)
      if (wa_q[wr_base + i] !== 9'(i) || wd_q[wr_base + i] !== 16'(i)) errs++;
    check("clamp_data_errs", 32'(errs), 32'd0);

    // Reset after 5 of 8 writes, then a fresh 2-bias load
    for (int k = 0; k < 4; k++) words_buf[k] = {16'(k * 2 + 16'h101), 16'(k * 2 + 16'h100)};
    run_load("abort", 8, 4, 0, 0, 5);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    snap = wa_q.size();
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_addr", 32'(addr_wr), 32'd0);
    check("mid_rst_data", 32'(data_wr), 32'd0);
    check("mid_rst_busy", 32'(load_busy), 32'd0);
    check("mid_rst_done", 32'(load_done), 32'd0);
    check("mid_rst_mem_ready", 32'(BiasMem_ready), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_writes", 32'(wa_q.size() - snap), 32'd0);
    words_buf[0] = 32'h0BEE_0ACE;
    wr_base = wa_q.size();
    run_load("after_rst", 2, 1, 0, 0, 0);
    check("after_rst_nwr", 32'(wa_q.size() - wr_base), 32'd2);
    if (wa_q.size() - wr_base == 2) begin
      check("after_rst_addr0", 32'(wa_q[wr_base]), 32'd0);
      check("after_rst_data0", 32'(wd_q[wr_base]), 32'h0ACE);
      check("after_rst_addr1", 32'(wa_q[wr_base + 1]), 32'd1);
      check("after_rst_data1", 32'(wd_q[wr_base + 1]), 32'h0BEE);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
